// File: rtl/ball_engine.sv
// ball_engine: ball motion for the pong datapath.
// Handles serve delay, wall bounce, paddle collision, miss detection and
// one-cycle score / paddle-hit pulses. Motion advances one pixel per axis on
// each move tick produced by a clk-cycle prescaler.
// Optional macro BALL_SPEEDUP_EN: each paddle hit shortens the tick period by
// 1/8 (floored at MIN_TICKS); the period reloads on a score and on reset.
module ball_engine #(
   parameter int unsigned SCREEN_W       = 640,
   parameter int unsigned SCREEN_H       = 480,
   parameter int unsigned BALL_SIZE      = 8,
   parameter int unsigned PADDLE_H       = 64,
   parameter int unsigned PADDLE_W       = 8,
   parameter int unsigned LEFT_PADDLE_X  = 16,
   parameter int unsigned RIGHT_PADDLE_X = 616,
   parameter int unsigned TICKS_PER_PX   = 100000,
   parameter int unsigned SERVE_DELAY    = 60
`ifdef BALL_SPEEDUP_EN
   ,
   parameter int unsigned MIN_TICKS      = 25000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_on,
   input  logic       serve,
   input  logic [9:0] paddle_left_y,
   input  logic [9:0] paddle_right_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       score_left,
   output logic       score_right,
   output logic       paddle_hit,
   output logic [1:0] state
);

   localparam logic [9:0]  CENTRE_X    = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0]  CENTRE_Y    = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0]  MAX_X       = 10'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0]  MAX_Y       = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0]  LEFT_HIT_X  = 10'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [10:0] RIGHT_HIT_X = 11'(RIGHT_PADDLE_X);
   localparam logic [10:0] BALL_SZ11   = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_H11     = 11'(PADDLE_H);
   localparam logic [31:0] TICKS       = 32'(TICKS_PER_PX);
   localparam logic [15:0] DELAY_LAST  = 16'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      MOVING = 2'd2,
      SCORED = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] presc_q;
   logic [15:0] delay_q;
   logic        dx_neg;
   logic        dy_neg;
   logic [31:0] period;

`ifdef BALL_SPEEDUP_EN
   localparam logic [31:0] MIN32 = 32'(MIN_TICKS);
   logic [31:0] period_q;
   logic [31:0] period_cut;
   logic [31:0] period_sped;
   assign period      = period_q;
   assign period_cut  = period_q - (period_q >> 3);
   assign period_sped = (period_cut < MIN32) ? MIN32 : period_cut;
`else
   assign period = TICKS;
`endif

   logic tick;
   assign tick = game_on && (state_q != IDLE) && (presc_q == period - 32'd1);

   // Vertical step: flip at top/bottom wall, then move by the new direction.
   logic       wall;
   logic       dy_new;
   logic [9:0] y_next;
   assign wall   = dy_neg ? (ball_y == '0) : (ball_y == MAX_Y);
   assign dy_new = dy_neg ^ wall;
   assign y_next = dy_new ? ball_y - 10'd1 : ball_y + 10'd1;

   // Paddle overlap and face tests use 11-bit sums so edges never wrap.
   logic [10:0] y11;
   logic        overlap_l;
   logic        overlap_r;
   logic        hit_l;
   logic        hit_r;
   logic        dx_new;
   logic [9:0]  x_next;
   logic        miss_l;
   logic        miss_r;
   assign y11       = {1'b0, ball_y};
   assign overlap_l = (y11 + BALL_SZ11 > {1'b0, paddle_left_y}) &&
                      (y11 < {1'b0, paddle_left_y} + PAD_H11);
   assign overlap_r = (y11 + BALL_SZ11 > {1'b0, paddle_right_y}) &&
                      (y11 < {1'b0, paddle_right_y} + PAD_H11);
   assign hit_l     = dx_neg && (ball_x == LEFT_HIT_X) && overlap_l;
   assign hit_r     = !dx_neg && ({1'b0, ball_x} + BALL_SZ11 == RIGHT_HIT_X) && overlap_r;
   assign dx_new    = dx_neg ^ (hit_l | hit_r);
   assign x_next    = dx_new ? ball_x - 10'd1 : ball_x + 10'd1;
   assign miss_l    = dx_neg && (ball_x == '0);
   assign miss_r    = !dx_neg && (ball_x == MAX_X);

   assign state = state_q;

   // Serve/move/score FSM with prescaler, position and registered pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         delay_q     <= '0;
         dx_neg      <= 1'b0;
         dy_neg      <= 1'b0;
         ball_x      <= CENTRE_X;
         ball_y      <= CENTRE_Y;
         score_left  <= 1'b0;
         score_right <= 1'b0;
         paddle_hit  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         period_q    <= TICKS;
`endif
      end else begin
         score_left  <= 1'b0;
         score_right <= 1'b0;
         paddle_hit  <= 1'b0;
         if (game_on) begin
            if (state_q != IDLE)
               presc_q <= tick ? '0 : presc_q + 32'd1;
            case (state_q)
               IDLE: begin
                  if (serve) begin
                     state_q <= DELAY;
                     delay_q <= '0;
                  end
               end
               DELAY: begin
                  if (tick) begin
                     if (delay_q == DELAY_LAST) state_q <= MOVING;
                     else                       delay_q <= delay_q + 16'd1;
                  end
               end
               MOVING: begin
                  if (tick) begin
                     if (miss_l || miss_r) begin
                        // Ball left the field: recentre now and serve toward the conceding side.
                        state_q     <= SCORED;
                        delay_q     <= '0;
                        ball_x      <= CENTRE_X;
                        ball_y      <= CENTRE_Y;
                        dx_neg      <= miss_l;
                        dy_neg      <= ~dy_neg;
                        score_right <= miss_l;
                        score_left  <= miss_r;
`ifdef BALL_SPEEDUP_EN
                        period_q    <= TICKS;
`endif
                     end else begin
                        dy_neg <= dy_new;
                        ball_y <= y_next;
                        dx_neg <= dx_new;
                        ball_x <= x_next;
                        if (hit_l || hit_r) begin
                           paddle_hit <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                           period_q   <= period_sped;
`endif
                        end
                     end
                  end
               end
               SCORED: begin
                  if (tick) begin
                     if (delay_q == DELAY_LAST) state_q <= IDLE;
                     else                       delay_q <= delay_q + 16'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Generates ball motion for the pong datapath; output `ball_y` drives the computer paddle's ball-tracking input.
- Owns serve, wall bounce, paddle collision and miss detection.
- Reads both paddle positions; emits one-cycle score pulses to the scoreboard.
- Ball moves one pixel per axis per move tick; tick rate comes from a cycle prescaler.

Parameters:
- SCREEN_W, 640, playfield width in px
- SCREEN_H, 480, playfield height in px
- BALL_SIZE, 8, ball edge length in px (square ball)
- PADDLE_H, 64, paddle height in px
- PADDLE_W, 8, paddle width in px
- LEFT_PADDLE_X, 16, left paddle left edge x
- RIGHT_PADDLE_X, 616, right paddle left edge x
- TICKS_PER_PX, 100000, clk cycles per move tick (minimum 2)
- SERVE_DELAY, 60, move ticks waited between serve/score and motion
- MIN_TICKS, 25000, floor for speed-up (SPEEDUP_EN only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- game_on  in  1  high = run; low = freeze all counters and position
- serve  in  1  one-cycle pulse to launch the ball from IDLE
- paddle_left_y  in  10  left paddle top-edge y
- paddle_right_y  in  10  right paddle top-edge y
- ball_x  out  10  ball left-edge x
- ball_y  out  10  ball top-edge y
- score_left  out  1  one-cycle pulse: left player scored (ball exited right)
- score_right  out  1  one-cycle pulse: right player scored (ball exited left)
- paddle_hit  out  1  one-cycle pulse on any paddle bounce
- state  out  2  0 IDLE, 1 DELAY, 2 MOVING, 3 SCORED

Behaviour:

Reset:
- Sampled at posedge `clk` while `reset`==0.
- Outputs: `ball_x`=(SCREEN_W-BALL_SIZE)/2 (316), `ball_y`=(SCREEN_H-BALL_SIZE)/2 (236).
- Pulses 0; `state`=IDLE; prescaler=0; dx=+1, dy=+1; tick period=TICKS_PER_PX.
- Reset mid-operation aborts everything immediately; no score pulse is emitted.

Prescaler:
- Counts clk cycles only while `game_on`=1 and `state`!=IDLE.
- At count==period-1 it wraps to 0 and asserts an internal move tick for one cycle.
- `game_on`=0 holds the count, position and state.

States:
- IDLE: ball held at centre. A `serve` pulse (with `game_on`=1) moves to DELAY and zeroes the delay counter. `serve` is ignored in any other state.
- DELAY: counts move ticks. After SERVE_DELAY ticks, goes to MOVING. The ball stays at centre.
- MOVING: on each move tick, evaluate in this order, all against current registered values:
  - Vertical: if dy=-1 and `ball_y`==0, or dy=+1 and `ball_y`==SCREEN_H-BALL_SIZE, flip dy. Then `ball_y` += new dy.
  - Left paddle: dx=-1, `ball_x`==LEFT_PADDLE_X+PADDLE_W, and overlap (`ball_y`+BALL_SIZE > `paddle_left_y` and `ball_y` < `paddle_left_y`+PADDLE_H).
  - Right paddle: dx=+1, `ball_x`+BALL_SIZE==RIGHT_PADDLE_X, same overlap test with `paddle_right_y`.
  - On a paddle hit: flip dx and pulse `paddle_hit`. Then `ball_x` += new dx.
  - Miss: dx=-1 and `ball_x`==0 → pulse `score_right` and go to SCORED. Or dx=+1 and `ball_x`==SCREEN_W-BALL_SIZE → pulse `score_left` and go to SCORED. The position does not move on that tick.
  - Wall and paddle bounce on the same tick (corner): both flips apply.
- SCORED: re-centre the ball on entry. Set dx toward the player who conceded; toggle dy. Wait SERVE_DELAY move ticks, then go to IDLE.

Arithmetic:
- Coordinates are unsigned 10-bit.
- Bounds checks above guarantee no underflow or overflow.
- Paddle-edge comparisons use 11-bit sums.

Timing:
- All outputs are registered.
- Position updates are visible the cycle after the move tick.

Optional Feature:
- Macro `BALL_SPEEDUP_EN`.
- Defined: each paddle hit sets period = max(period - period/8, MIN_TICKS). The period reloads to TICKS_PER_PX on entry to SCORED and on reset.
- Undefined: period is constant TICKS_PER_PX; MIN_TICKS is unused.

Test Plan:
- Reset released, no serve, 1000 cycles (TICKS_PER_PX=2, SERVE_DELAY=3) → `ball_x`=316, `ball_y`=236, `state`=0, no pulses.
- `serve` pulse → `state`=1 for 6 cycles, then 2. First move tick gives `ball_x`=317, `ball_y`=237.
- Ball at y=472 with dy=+1 → next tick y=471, dy=-1. Ball at y=0 with dy=-1 → next tick y=1.
- Left paddle: `paddle_left_y`=200, ball x=24, y=230, dx=-1 → `paddle_hit` pulse, next x=25. Same case with `paddle_left_y`=300 → ball continues to x=0, then one `score_right` pulse, `state`=3, ball recentred, dx=-1.
- `game_on` deasserted mid-MOVING for 50 cycles → position and prescaler frozen; motion resumes exactly where it stopped.
- With `BALL_SPEEDUP_EN`, TICKS_PER_PX=64, MIN_TICKS=40: hits give periods 56, 49, 43, 40, 40. A score restores 64.
